// File: rtl/ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle and single-cycle decoders.
// States, opcodes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd13
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic lw;
    logic sw;
    logic r;
    logic i;
    logic br;
    logic jal;
    logic lui;
  } iclass_t;

endpackage

// File: rtl/instr_class_dec.sv
// Opcode classifier: immediate format, one-hot class and illegal flag.
// Shared by the multi-cycle sequencer and the single-cycle decoder.
module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o,
  output iclass_t    cls_o,
  output logic       illegal_o
);

  always_comb begin
    imm_src_o = IMM_I;
    cls_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_LW: cls_o.lw = 1'b1;
      OP_SW: begin
        cls_o.sw  = 1'b1;
        imm_src_o = IMM_S;
      end
      OP_R:  cls_o.r = 1'b1;
      OP_I:  cls_o.i = 1'b1;
      OP_BR: begin
        cls_o.br  = 1'b1;
        imm_src_o = IMM_B;
      end
      OP_JAL: begin
        cls_o.jal = 1'b1;
        imm_src_o = IMM_J;
      end
      OP_LUI: begin
        cls_o.lui = 1'b1;
        imm_src_o = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: steps fetch/decode/execute/writeback
// and drives the datapath selects and write enables.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit HAS_MEM_READY = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] imm_src_o,
  output logic       instret_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e  state_q, state_d;
  iclass_t cls;
  logic    dec_illegal;
  logic    mem_rdy;
  logic    br_taken;

  instr_class_dec u_dec (
    .op_i      (op_i),
    .imm_src_o (imm_src_o),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  assign mem_rdy  = HAS_MEM_READY ? mem_ready_i : 1'b1;
  assign br_taken = ((funct3_i == F3_BEQ) &  zero_i) |
                    ((funct3_i == F3_BNE) & ~zero_i);
  assign state_o  = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    alu_op_o     = ALUOP_ADD;
    instret_o    = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        ir_write_o   = mem_rdy;
        pc_write_o   = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        if (dec_illegal) begin
          state_d = S_ILLEGAL;
        end else begin
          unique case (1'b1)
            cls.lw, cls.sw: state_d = S_MEMADR;
            cls.r:          state_d = S_EXECR;
            cls.i:          state_d = S_EXECI;
            cls.br:         state_d = S_BRANCH;
            cls.jal:        state_d = S_JAL;
            cls.lui:        state_d = S_LUI;
            default:        state_d = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        state_d     = cls.sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = RES_MEM;
        reg_write_o  = 1'b1;
        instret_o    = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        instret_o   = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_o = SRCA_ZERO;
        alu_src_b_o = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        instret_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALUOP_SUB;
        pc_write_o  = br_taken;
        instret_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // ALUOut already holds the target; ALU now forms oldPC+4 for rd
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Async reset already forces FETCH; also squash its ready-gated enables
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      instret_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: vector table, hand sequences,
// and randomized instructions against a per-instruction transaction model.
module tb_mc_ctrl_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       adr_src_o;
  logic       mem_write_o;
  logic       reg_write_o;
  logic [1:0] result_src_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [2:0] imm_src_o;
  logic       instret_o;
  logic       illegal_o;
  logic [3:0] state_o;

  mc_ctrl_fsm #(.HAS_MEM_READY(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .adr_src_o    (adr_src_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .result_src_o (result_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .imm_src_o    (imm_src_o),
    .instret_o    (instret_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;

  int errors = 0;
  int checks = 0;

  logic       rdy [64];
  logic [3:0] tr_state [64];
  logic       tr_regw [64];
  logic       tr_memw [64];
  logic       tr_adr [64];
  logic       tr_pcw [64];
  logic [1:0] tr_a [64];
  int n, c_pcw, c_regw, c_memw, c_adr, c_ir, c_inst, c_excl, c_imm_bad;
  logic [1:0] res_at_wb;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    if (op == SW)  return 3'b001;
    if (op == BR)  return 3'b010;
    if (op == LUI) return 3'b011;
    if (op == JAL) return 3'b100;
    return 3'b000;
  endfunction

  task automatic do_reset();
    rst_i       = 1'b1;
    mem_ready_i = 1'b0;
    op_i        = RT;
    funct3_i    = 3'b000;
    zero_i      = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic z);
    bit done;
    done = 0;
    n = 0; c_pcw = 0; c_regw = 0; c_memw = 0; c_adr = 0; c_ir = 0;
    c_inst = 0; c_excl = 0; c_imm_bad = 0; res_at_wb = 2'b11;
    while (!done && n < 64) begin
      @(negedge clk_i);
      op_i = op; funct3_i = f3; zero_i = z; mem_ready_i = rdy[n];
      #1;
      tr_state[n] = state_o;
      tr_regw[n]  = reg_write_o;
      tr_memw[n]  = mem_write_o;
      tr_adr[n]   = adr_src_o;
      tr_pcw[n]   = pc_write_o;
      tr_a[n]     = alu_src_a_o;
      c_pcw  += int'(pc_write_o);
      c_regw += int'(reg_write_o);
      c_memw += int'(mem_write_o);
      c_adr  += int'(adr_src_o);
      c_ir   += int'(ir_write_o);
      c_inst += int'(instret_o);
      if (reg_write_o) res_at_wb = result_src_o;
      if (imm_src_o != exp_imm(op)) c_imm_bad++;
      if (int'(pc_write_o) + int'(mem_write_o) + int'(reg_write_o) > 1)
        c_excl++;
      n++;
      if (instret_o) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%b: no instret within 64 cycles", op);
    end
  endtask

  function automatic void all_ready();
    for (int k = 0; k < 64; k++) rdy[k] = 1'b1;
  endfunction

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         cyc;
    int         pcw;
    int         regw;
    int         memw;
    logic [2:0] imm;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{RT,  3'b000, 1'b0, 4, 1, 1, 0, 3'b000};
    vecs[1]  = '{IT,  3'b000, 1'b0, 4, 1, 1, 0, 3'b000};
    vecs[2]  = '{LUI, 3'b000, 1'b0, 4, 1, 1, 0, 3'b011};
    vecs[3]  = '{JAL, 3'b000, 1'b0, 4, 2, 1, 0, 3'b100};
    vecs[4]  = '{LW,  3'b010, 1'b0, 5, 1, 1, 0, 3'b000};
    vecs[5]  = '{SW,  3'b010, 1'b0, 4, 1, 0, 1, 3'b001};
    vecs[6]  = '{BR,  3'b000, 1'b1, 3, 2, 0, 0, 3'b010};
    vecs[7]  = '{BR,  3'b000, 1'b0, 3, 1, 0, 0, 3'b010};
    vecs[8]  = '{BR,  3'b001, 1'b1, 3, 1, 0, 0, 3'b010};
    vecs[9]  = '{BR,  3'b001, 1'b0, 3, 2, 0, 0, 3'b010};
    vecs[10] = '{BR,  3'b100, 1'b0, 3, 1, 0, 0, 3'b010};

    do_reset();
    mem_ready_i = 1'b1;
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_ir_write", int'(ir_write_o), 1);
    chk("rst_reg_write", int'(reg_write_o), 0);
    chk("rst_mem_write", int'(mem_write_o), 0);
    chk("rst_illegal", int'(illegal_o), 0);
    #1 mem_ready_i = 1'b0;

    all_ready();
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].z);
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("vec%0d_pcw", i), c_pcw, vecs[i].pcw);
      chk($sformatf("vec%0d_regw", i), c_regw, vecs[i].regw);
      chk($sformatf("vec%0d_memw", i), c_memw, vecs[i].memw);
      chk($sformatf("vec%0d_imm_bad", i), c_imm_bad, 0);
    end

    // R-type state walk
    run_instr(RT, 3'b000, 1'b0);
    chk("r_s0", int'(tr_state[0]), 0);
    chk("r_s1", int'(tr_state[1]), 1);
    chk("r_s2", int'(tr_state[2]), 6);
    chk("r_s3", int'(tr_state[3]), 9);
    chk("r_regw_c4", int'(tr_regw[3]), 1);
    chk("r_regw_cnt", c_regw, 1);
    chk("r_instret", c_inst, 1);

    // lw with two stalls in MEMREAD
    all_ready(); rdy[3] = 1'b0; rdy[4] = 1'b0;
    run_instr(LW, 3'b010, 1'b0);
    chk("lw_cycles", n, 7);
    chk("lw_adr_stall0", int'(tr_adr[3]), 1);
    chk("lw_adr_stall1", int'(tr_adr[4]), 1);
    chk("lw_regw_cnt", c_regw, 1);
    chk("lw_res_src", int'(res_at_wb), 1);
    chk("lw_imm_bad", c_imm_bad, 0);

    // sw with three stalls
    all_ready(); rdy[3] = 1'b0; rdy[4] = 1'b0; rdy[5] = 1'b0;
    run_instr(SW, 3'b010, 1'b0);
    chk("sw_cycles", n, 7);
    chk("sw_memw_cnt", c_memw, 4);
    chk("sw_memw_consec", int'(tr_memw[3] & tr_memw[4] & tr_memw[5] &
                               tr_memw[6]), 1);
    chk("sw_instret", c_inst, 1);
    chk("sw_regw", c_regw, 0);

    // lui
    all_ready();
    run_instr(LUI, 3'b000, 1'b0);
    chk("lui_state", int'(tr_state[2]), 8);
    chk("lui_src_a", int'(tr_a[2]), 3);
    chk("lui_imm_bad", c_imm_bad, 0);

    // illegal opcode is absorbing
    begin
      int bad;
      bad = 0;
      op_i = 7'b1111111; mem_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        #1;
        if (!illegal_o || pc_write_o || ir_write_o || mem_write_o ||
            reg_write_o || instret_o || state_o != 4'd13) bad++;
      end
      chk("illegal_hold", bad, 0);
    end
    do_reset();

    // reset mid-MEMWRITE
    op_i = SW; funct3_i = 3'b010; mem_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    chk("mw_state", int'(state_o), 5);
    chk("mw_memw_pre", int'(mem_write_o), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("mw_memw_rst", int'(mem_write_o), 0);
    chk("mw_state_rst", int'(state_o), 0);
    do_reset();

    // randomized instructions vs transaction model
    begin
      logic [6:0] ops [7];
      ops = '{LW, SW, RT, IT, BR, JAL, LUI};
      for (int t = 0; t < 150; t++) begin
        logic [6:0] op;
        logic [2:0] f3;
        logic z;
        int base, f, m, total, e_pcw, e_regw, e_memw, e_adr, p;
        bit mem_op, taken;
        op = ops[$urandom_range(0, 6)];
        f3 = 3'($urandom_range(0, 7));
        z  = 1'($urandom_range(0, 1));
        for (int k = 0; k < 64; k++)
          rdy[k] = (k >= 20) ? 1'b1 : ($urandom_range(0, 9) < 7);
        mem_op = (op == LW) || (op == SW);
        base = (op == LW) ? 5 : (op == BR) ? 3 : 4;
        f = 0;
        while (!rdy[f]) f++;
        m = 0;
        if (mem_op) begin
          p = f + 3;
          while (!rdy[p]) begin m++; p++; end
        end
        total = base + f + m;
        taken = (op == BR) && ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z));
        e_pcw  = 1 + int'(op == JAL) + int'(taken);
        e_regw = (op == SW || op == BR) ? 0 : 1;
        e_memw = (op == SW) ? m + 1 : 0;
        e_adr  = mem_op ? m + 1 : 0;
        run_instr(op, f3, z);
        chk("rnd_cycles", n, total);
        chk("rnd_pcw", c_pcw, e_pcw);
        chk("rnd_irw", c_ir, 1);
        chk("rnd_regw", c_regw, e_regw);
        chk("rnd_memw", c_memw, e_memw);
        chk("rnd_adr", c_adr, e_adr);
        chk("rnd_imm_bad", c_imm_bad, 0);
        chk("rnd_excl", c_excl, 0);
        if (e_regw == 1)
          chk("rnd_res_src", int'(res_at_wb), (op == LW) ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
